// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM state codes,
// and the size/alignment helpers used by the bus FSM and lane aligner.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    // funct3 bit selecting zero-extension on loads
    localparam int OP_UNS = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MREQ  = 2'd1;
    localparam logic [1:0] ST_MRESP = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

    // Size alignment check; ldu (3'b111) and d-size on a 32-bit unit are
    // never legal. Stores ignore the unsigned bit, so sd stays legal.
    function automatic logic misaligned(input logic wr, input logic [2:0] op,
                                        input logic [2:0] a, input int xlen);
        logic m;
        case (op[1:0])
            SZ_H:    m = a[0];
            SZ_W:    m = |a[1:0];
            SZ_D:    m = (|a) | (xlen == 32);
            default: m = 1'b0;
        endcase
        return m | (!wr && op == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_bus_if.sv
// Pipeline request/response and data-memory port of the load/store unit.
// master = the LSU (masters the memory port), slave = its surroundings.
interface lsu_bus_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = XLEN
);
    localparam int NB = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_misalign;
    logic              resp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_wr;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [XLEN-1:0]   mem_req_wdata;
    logic [NB-1:0]     mem_req_strb;

    logic              mem_resp_valid;
    logic [XLEN-1:0]   mem_resp_rdata;
    logic              mem_resp_err;

    modport master (
        input  req_valid, req_wr, req_op, req_addr, req_wdata, resp_ready,
               mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
        output req_ready, resp_valid, resp_rdata, resp_misalign, resp_err,
               mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_strb
    );

    modport slave (
        output req_valid, req_wr, req_op, req_addr, req_wdata, resp_ready,
               mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
        input  req_ready, resp_valid, resp_rdata, resp_misalign, resp_err,
               mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_strb
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: shifts store data and builds strobes,
// and pulls the addressed field out of a load beat with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int  XLEN  = 64,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [1:0]       size,
    input  logic             uns,
    input  logic [OFF_W-1:0] off,
    input  logic [XLEN-1:0]  st_data,
    input  logic [XLEN-1:0]  ld_beat,
    output logic [XLEN-1:0]  st_wdata,
    output logic [NB-1:0]    st_strb,
    output logic [XLEN-1:0]  ld_data
);
    logic [OFF_W+2:0] sh_bits;
    logic [NB-1:0]    mask;
    logic [XLEN-1:0]  ld_sh;
    logic             msb;

    assign sh_bits = {off, 3'b000};

    // Store side: right-justified data and a size-wide mask moved up to the lane.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NB; i++)
            if (i < int'(size_bytes(size))) mask[i] = 1'b1;
        st_strb  = mask << off;
        st_wdata = st_data << sh_bits;
    end

    // Load side: bring the lane down to bit 0, then fill above the field.
    always_comb begin
        ld_sh = ld_beat >> sh_bits;
        case (size)
            SZ_B:    msb = ld_sh[7];
            SZ_H:    msb = ld_sh[15];
            SZ_W:    msb = ld_sh[31];
            default: msb = ld_sh[XLEN-1];
        endcase
        ld_data = ld_sh;
        for (int i = 0; i < XLEN; i++)
            if (i >= 8 * int'(size_bytes(size))) ld_data[i] = msb & ~uns;
    end

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit bus master: one access at a time through IDLE -> MREQ ->
// MRESP -> RESP. Misaligned accesses go straight to RESP with no memory
// traffic. Every output is decoded from registered state.
module lsu_bus
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = XLEN
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_bus_if.master bus,
    output logic      busy
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    logic [1:0]        state;
    logic              r_wr;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rdata;
    logic              r_mis;
    logic              r_err;

    logic              req_mis;
    logic              in_mreq;
    logic              in_resp;
    logic [XLEN-1:0]   st_wdata;
    logic [NB-1:0]     st_strb;
    logic [XLEN-1:0]   ld_data;

    assign req_mis = misaligned(bus.req_wr, bus.req_op, bus.req_addr[2:0], XLEN);

    // Aligner always works on the latched request; only the load beat is live.
    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .size     (r_op[1:0]),
        .uns      (r_op[OP_UNS]),
        .off      (r_addr[OFF_W-1:0]),
        .st_data  (r_wdata),
        .ld_beat  (bus.mem_resp_rdata),
        .st_wdata (st_wdata),
        .st_strb  (st_strb),
        .ld_data  (ld_data)
    );

    // Access FSM plus latched request and captured response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            r_wr    <= 1'b0;
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_mis   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.req_valid) begin
                    r_wr    <= bus.req_wr;
                    // unsigned bit has no meaning for stores
                    r_op    <= {bus.req_op[2] & ~bus.req_wr, bus.req_op[1:0]};
                    r_addr  <= bus.req_addr;
                    r_wdata <= bus.req_wdata;
                    r_rdata <= '0;
                    r_mis   <= req_mis;
                    r_err   <= 1'b0;
                    state   <= req_mis ? ST_RESP : ST_MREQ;
                end
                ST_MREQ: if (bus.mem_req_ready) state <= ST_MRESP;
                ST_MRESP: if (bus.mem_resp_valid) begin
                    r_err   <= bus.mem_resp_err;
                    r_rdata <= (r_wr || bus.mem_resp_err) ? '0 : ld_data;
                    state   <= ST_RESP;
                end
                default: if (bus.resp_ready) state <= ST_IDLE;
            endcase
        end
    end

    assign in_mreq = (state == ST_MREQ);
    assign in_resp = (state == ST_RESP);

    assign bus.req_ready     = (state == ST_IDLE);
    assign busy              = (state != ST_IDLE);

    // Memory request fields read as zero outside MREQ.
    assign bus.mem_req_valid = in_mreq;
    assign bus.mem_req_wr    = in_mreq & r_wr;
    assign bus.mem_req_addr  = in_mreq ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign bus.mem_req_wdata = (in_mreq & r_wr) ? st_wdata : '0;
    assign bus.mem_req_strb  = !in_mreq ? '0 : (r_wr ? st_strb : '1);

    assign bus.resp_valid    = in_resp;
    assign bus.resp_rdata    = in_resp ? r_rdata : '0;
    assign bus.resp_misalign = in_resp & r_mis;
    assign bus.resp_err      = in_resp & r_err;

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus at XLEN=64 and XLEN=32. Stimulus pushes the
// expected memory requests and responses into queues; a negedge monitor pops
// and compares them on each handshake.
module tb_lsu_bus;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_bus_if #(.XLEN(64)) b64 ();
    lsu_bus_if #(.XLEN(32)) b32 ();
    logic busy64, busy32;

    lsu_bus #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64), .busy(busy64));
    lsu_bus #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32), .busy(busy32));

    // shared stimulus; sel32 steers req_valid and the observed outputs
    logic        sel32;
    logic        req_valid, req_wr, resp_ready, mem_req_ready, mem_resp_valid, mem_resp_err;
    logic [2:0]  req_op;
    logic [63:0] req_addr, req_wdata, mem_resp_rdata;

    assign b64.req_valid      = req_valid & ~sel32;
    assign b32.req_valid      = req_valid & sel32;
    assign b64.req_wr         = req_wr;
    assign b32.req_wr         = req_wr;
    assign b64.req_op         = req_op;
    assign b32.req_op         = req_op;
    assign b64.req_addr       = req_addr;
    assign b32.req_addr       = req_addr[31:0];
    assign b64.req_wdata      = req_wdata;
    assign b32.req_wdata      = req_wdata[31:0];
    assign b64.resp_ready     = resp_ready;
    assign b32.resp_ready     = resp_ready;
    assign b64.mem_req_ready  = mem_req_ready;
    assign b32.mem_req_ready  = mem_req_ready;
    assign b64.mem_resp_valid = mem_resp_valid;
    assign b32.mem_resp_valid = mem_resp_valid;
    assign b64.mem_resp_rdata = mem_resp_rdata;
    assign b32.mem_resp_rdata = mem_resp_rdata[31:0];
    assign b64.mem_resp_err   = mem_resp_err;
    assign b32.mem_resp_err   = mem_resp_err;

    logic        o_req_ready, o_resp_valid, o_mis, o_err, o_mv, o_mwr, o_busy;
    logic [63:0] o_rdata, o_maddr, o_mwdata;
    logic [7:0]  o_mstrb;

    assign o_req_ready  = sel32 ? b32.req_ready     : b64.req_ready;
    assign o_resp_valid = sel32 ? b32.resp_valid    : b64.resp_valid;
    assign o_mis        = sel32 ? b32.resp_misalign : b64.resp_misalign;
    assign o_err        = sel32 ? b32.resp_err      : b64.resp_err;
    assign o_rdata      = sel32 ? 64'(b32.resp_rdata) : b64.resp_rdata;
    assign o_mv         = sel32 ? b32.mem_req_valid : b64.mem_req_valid;
    assign o_mwr        = sel32 ? b32.mem_req_wr    : b64.mem_req_wr;
    assign o_maddr      = sel32 ? 64'(b32.mem_req_addr)  : b64.mem_req_addr;
    assign o_mwdata     = sel32 ? 64'(b32.mem_req_wdata) : b64.mem_req_wdata;
    assign o_mstrb      = sel32 ? {4'h0, b32.mem_req_strb} : b64.mem_req_strb;
    assign o_busy       = sel32 ? busy32 : busy64;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
    } mrq_t;
    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        logic        err;
    } rsp_t;

    mrq_t mq[$];
    rsp_t rq[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    logic saw_mreq;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    task automatic expm(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] strb);
        mq.push_back('{wr, addr, wdata, strb});
    endtask

    task automatic expr(input logic [63:0] rdata, input logic mis, input logic err);
        rq.push_back('{rdata, mis, err});
    endtask

    // monitor: compare against the queues on every handshake
    always @(negedge clk) begin
        mrq_t m;
        rsp_t r;
        if (o_mv) saw_mreq = 1'b1;
        if (o_mv && mem_req_ready) begin
            if (mq.size() == 0) chk("mreq_unexpected", 64'd1, 64'd0);
            else begin
                m = mq.pop_front();
                chk("mreq_wr",    64'(o_mwr), 64'(m.wr));
                chk("mreq_addr",  o_maddr,  m.addr);
                chk("mreq_wdata", o_mwdata, m.wdata);
                chk("mreq_strb",  64'(o_mstrb), 64'(m.strb));
            end
        end
        if (o_resp_valid && resp_ready) begin
            if (rq.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
            else begin
                r = rq.pop_front();
                chk("resp_rdata",    o_rdata, r.rdata);
                chk("resp_misalign", 64'(o_mis), 64'(r.mis));
                chk("resp_err",      64'(o_err), 64'(r.err));
            end
        end
    end

    // One access with memory always ready; checks accept-to-response latency.
    // Entered and left at posedge+1.
    task automatic run(input bit s32, input logic wr, input logic [2:0] op,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rdata, input int exp_lat);
        int n;
        sel32 = s32;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_err = 1'b0;
        mem_resp_rdata = rdata; resp_ready = 1'b1;
        #1;
        chk("req_ready_idle", 64'(o_req_ready), 64'd1);
        saw_mreq = 1'b0;
        req_valid = 1'b1; req_wr = wr; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_resp_valid && n < 20);
        chk("latency", 64'(n), 64'(exp_lat));
        @(posedge clk); #1;
        if (exp_lat == 1) chk("no_mem_traffic", 64'(saw_mreq), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [139:0] snap;
        logic         stable, hold;

        sel32 = 1'b0; rst_n = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_err = 1'b0; mem_resp_rdata = '0;
        saw_mreq = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req_valid", 64'(o_mv), 64'd0);
        chk("rst_mem_req_strb",  64'(o_mstrb), 64'd0);
        chk("rst_resp_valid",    64'(o_resp_valid), 64'd0);
        chk("rst_busy",          64'(o_busy), 64'd0);
        chk("rst_busy32",        64'(busy32), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 chk("rst_req_ready", 64'(o_req_ready), 64'd1);
        @(posedge clk); #1;

        // sb to byte 5
        expm(1'b1, 64'h8000_0000, 64'h0000_AB00_0000_0000, 8'h20);
        expr(64'h0, 1'b0, 1'b0);
        run(0, 1'b1, 3'b000, 64'h8000_0005, 64'hAB, 64'h0, 3);

        // lh / lhu at offset 2
        expm(1'b0, 64'h8000_0000, 64'h0, 8'hFF);
        expr(64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b0);
        run(0, 1'b0, 3'b001, 64'h8000_0002, 64'h0, 64'h0000_0000_8001_0000, 3);
        expm(1'b0, 64'h8000_0000, 64'h0, 8'hFF);
        expr(64'h0000_0000_0000_8001, 1'b0, 1'b0);
        run(0, 1'b0, 3'b101, 64'h8000_0002, 64'h0, 64'h0000_0000_8001_0000, 3);

        // misaligned lw: response in cycle 1, no memory request
        expr(64'h0, 1'b1, 1'b0);
        run(0, 1'b0, 3'b010, 64'h8000_0006, 64'h0, 64'h0, 1);

        // lw upper word, lbu top byte
        expm(1'b0, 64'h8000_0000, 64'h0, 8'hFF);
        expr(64'hFFFF_FFFF_89AB_CDEF, 1'b0, 1'b0);
        run(0, 1'b0, 3'b010, 64'h8000_0004, 64'h0, 64'h89AB_CDEF_0123_4567, 3);
        expm(1'b0, 64'h8000_0000, 64'h0, 8'hFF);
        expr(64'h0000_0000_0000_0089, 1'b0, 1'b0);
        run(0, 1'b0, 3'b100, 64'h8000_0007, 64'h0, 64'h89AB_CDEF_0123_4567, 3);

        // sh with unsigned bit set behaves as sh; junk above the halfword shifts out
        expm(1'b1, 64'h0, 64'h1234_0000_0000_0000, 8'hC0);
        expr(64'h0, 1'b0, 1'b0);
        run(0, 1'b1, 3'b101, 64'h6, 64'hFFFF_1234, 64'h0, 3);

        // ldu is illegal even when aligned; "sdu" is a plain sd
        expr(64'h0, 1'b1, 1'b0);
        run(0, 1'b0, 3'b111, 64'h8, 64'h0, 64'h0, 1);
        expm(1'b1, 64'h10, 64'h1122_3344_5566_7788, 8'hFF);
        expr(64'h0, 1'b0, 1'b0);
        run(0, 1'b1, 3'b111, 64'h10, 64'h1122_3344_5566_7788, 64'h0, 3);

        // ld: memory stalls 5 cycles, returns an error, response held 3 cycles
        expm(1'b0, 64'h8000_0008, 64'h0, 8'hFF);
        expr(64'h0, 1'b0, 1'b1);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; resp_ready = 1'b0;
        mem_resp_err = 1'b1; mem_resp_rdata = 64'h5555_AAAA_5555_AAAA;
        req_valid = 1'b1; req_wr = 1'b0; req_op = 3'b011; req_addr = 64'h8000_0008; req_wdata = '0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        snap = {o_mv, o_mwr, o_maddr, o_mwdata, o_mstrb, 2'b00};
        stable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if ({o_mv, o_mwr, o_maddr, o_mwdata, o_mstrb, 2'b00} !== snap) stable = 1'b0;
        end
        chk("stall_mreq_valid",  64'(o_mv), 64'd1);
        chk("stall_mreq_stable", 64'(stable), 64'd1);
        @(posedge clk); #1 mem_req_ready = 1'b1;
        @(posedge clk); #1 mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        @(posedge clk); #1 mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        hold = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (!(o_resp_valid && o_err && o_rdata == 64'h0)) hold = 1'b0;
        end
        chk("resp_held", 64'(hold), 64'd1);
        @(posedge clk); #1 resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_done_idle", 64'(o_busy), 64'd0);

        // reset while waiting in MRESP, then a stale memory response
        expm(1'b0, 64'h8000_0000, 64'h0, 8'hFF);
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
        req_valid = 1'b1; req_wr = 1'b0; req_op = 3'b000; req_addr = 64'h8000_0003;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mresp_busy", 64'(o_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",       64'(o_busy), 64'd0);
        chk("midrst_mreq_valid", 64'(o_mv), 64'd0);
        chk("midrst_mreq_addr",  o_maddr, 64'd0);
        chk("midrst_resp_valid", 64'(o_resp_valid), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1 mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("stale_resp_ignored", 64'(o_resp_valid), 64'd0);
        chk("stale_resp_idle",    64'(o_busy), 64'd0);
        @(posedge clk); #1;
        expm(1'b0, 64'h8000_0000, 64'h0, 8'hFF);
        expr(64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0);
        run(0, 1'b0, 3'b000, 64'h8000_0003, 64'h0, 64'h0000_0000_F000_0000, 3);

        // XLEN=32 unit
        expr(64'h0, 1'b1, 1'b0);
        run(1, 1'b0, 3'b011, 64'h0, 64'h0, 64'h0, 1);
        expm(1'b1, 64'h4, 64'hCAFE_BABE, 8'h0F);
        expr(64'h0, 1'b0, 1'b0);
        run(1, 1'b1, 3'b010, 64'h4, 64'hCAFE_BABE, 64'h0, 3);
        expm(1'b1, 64'h4, 64'h5A00_0000, 8'h08);
        expr(64'h0, 1'b0, 1'b0);
        run(1, 1'b1, 3'b000, 64'h7, 64'h5A, 64'h0, 3);
        expm(1'b0, 64'h0, 64'h0, 8'h0F);
        expr(64'h0000_0000_FFFF_8001, 1'b0, 1'b0);
        run(1, 1'b0, 3'b001, 64'h2, 64'h0, 64'h8001_0000, 3);

        chk("mreq_queue_drained", 64'(mq.size()), 64'd0);
        chk("resp_queue_drained", 64'(rq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_bus.md
# lsu_bus

Parametrised load/store unit for the L/S stage: it replaces the DPI read-modify-write path with a multi-cycle valid/ready master on a data-memory port. The port uses byte strobes, and the memory completes each access with a response. The unit takes one load/store request from the pipeline at a time, raises a misalignment fault without touching memory, aligns and strobes store data, and sign- or zero-extends load data. It sits between `ls_ctr` decode and the write-back register.

## Interface
Parameters:
- XLEN, 64, data width; legal values 32 or 64.
- ADDR_W, XLEN, address width.
- NB, XLEN/8, bytes per beat (derived; not overridable).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline presents an access.
- req_ready  out  1  unit accepts; high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_op  in  3  funct3: [1:0] size (b/h/w/d), [2] unsigned (loads only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  result/fault available.
- resp_ready  in  1  pipeline consumes response.
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- resp_misalign  out  1  address not size-aligned, or size d when XLEN=32.
- resp_err  out  1  memory returned error.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_wr  out  1  write.
- mem_req_addr  out  ADDR_W  req_addr with low log2(NB) bits cleared.
- mem_req_wdata  out  XLEN  store data shifted to byte lane.
- mem_req_strb  out  NB  byte enables; all ones for loads.
- mem_resp_valid  in  1  memory completion; always accepted (no ready).
- mem_resp_rdata  in  XLEN  full aligned beat.
- mem_resp_err  in  1  access fault.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, MREQ, MRESP, RESP.
- IDLE:
  - req_valid & req_ready latches wr/op/addr/wdata.
  - If misaligned: go to RESP with resp_misalign=1 and no memory traffic.
  - Otherwise go to MREQ.
- MREQ: holds mem_req_* stable while valid. On mem_req_ready, go to MRESP.
- MRESP: on mem_resp_valid, capture the extracted/extended data and err, then go to RESP. A mem_resp_valid seen outside MRESP is ignored.
- RESP: holds resp_* stable while valid. On resp_ready, go to IDLE.
- Alignment rules:
  - h requires addr[0]=0.
  - w requires addr[1:0]=0.
  - d requires addr[2:0]=0.
  - b is always aligned.
- Store lane:
  - wdata = req_wdata << (8·off), where off = addr[log2(NB)-1:0].
  - strb = ((1<<bytes)-1) << off.
- Load extract: byte lane at off, width per size. Bit 2 of req_op selects zero- vs sign-extension to XLEN. req_op=3'b111 is treated as misaligned.
- Unsigned store ops (bit 2 set) are treated as bit 2 = 0.

## Timing
- Reset values:
  - State IDLE; req_ready=1 once rst_n is high.
  - All other outputs 0 (mem_req_*, resp_*, busy).
- Reset mid-access returns to IDLE immediately. Any in-flight memory response is dropped.
- All outputs are registered or decoded from registered state only. There is no combinational path from req_* to mem_req_* or from mem_resp_* to resp_*.
- Minimum aligned latency, with request accepted at edge 0:
  - mem_req_valid in cycle 1.
  - MRESP in cycle 2 if mem_req_ready was high in cycle 1.
  - resp_valid in cycle 3 if mem_resp_valid was high in cycle 2.
  - Total: 3 cycles from accept to response.
- Misaligned latency: resp_valid in cycle 1.
- Back-to-back: a new request is accepted in the cycle after the resp_valid & resp_ready handshake (req_ready rises then). Throughput is 1 access per 4 cycles at best.
- mem_req_ready and mem_resp_valid may stall indefinitely; no timeout.

## Structure
- `lsu_pkg`: memop encodings (SZ_B/H/W/D, unsigned bit), state enum, function for size-to-byte-count.
- Sub-module `lsu_lane_align`: purely combinational. Provides store shift/strb generation and load extract/extend, parametrised by XLEN. It is instantiated once in `lsu_bus`, which holds only the FSM and registers.

## Test plan
- XLEN=64 `sb` addr 0x8000_0005, wdata 0xAB, mem_req_ready=1 → mem_req_addr 0x8000_0000, strb 0x20, wdata 0x0000_AB00_0000_0000; resp_valid at cycle 3, rdata 0.
- `lh` addr 0x...2, mem_resp_rdata 0x0000_0000_8001_0000 → rdata 0xFFFF_FFFF_FFFF_8001. Same with `lhu` → 0x0000_0000_0000_8001.
- `lw` addr 0x...6 → resp_misalign=1 in cycle 1; mem_req_valid never rises.
- `ld` with mem_req_ready low 5 cycles and mem_resp_err=1 → mem_req_* stable throughout; resp_err=1; resp held 3 cycles while resp_ready=0.
- rst_n pulsed low while in MRESP → outputs 0 immediately; late mem_resp_valid ignored; next `lb` completes normally.
- XLEN=32 `ld` → resp_misalign=1; `lw` addr 0x4 → strb 0xF.
